// File: rtl/uart_seq_rx.sv
// 8N1 UART receiver that packs bytes LSB-first into WIDTH-bit words and groups
// DEPTH words into one sequence, handed to the sorter over valid/ready.
module uart_seq_rx #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 115_200,
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 8,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   uart_rx,
  output logic [DEPTH*WIDTH-1:0] seq_data,
  output logic                   seq_valid,
  input  logic                   seq_ready,
  output logic                   frame_err,
  output logic                   overrun,
  output logic [15:0]            seq_count
);
  localparam int CLKS_PER_BIT   = CLK_FREQ / BAUD;
  localparam int HALF_BIT       = CLKS_PER_BIT / 2;
  localparam int BYTES_PER_WORD = WIDTH / 8;
  localparam int TIMEOUT_CLKS   = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CNT_W          = $clog2(CLKS_PER_BIT + 1);
  localparam int BIDX_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int WIDX_W         = $clog2(DEPTH);
  localparam int TO_W           = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

  logic              rx_meta_q, rx_s_q;
  rx_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q;
  logic              byte_valid_q, frame_err_q;

  logic [BIDX_W-1:0]      byte_idx_q;
  logic [WIDX_W-1:0]      word_idx_q;
  logic [TO_W-1:0]        to_cnt_q;
  logic [WIDTH-1:0]       word_q, word_d;
  logic [DEPTH*WIDTH-1:0] asm_q, asm_d;
  logic [DEPTH*WIDTH-1:0] seq_data_q;
  logic                   seq_valid_q, overrun_q;
  logic [15:0]            seq_count_q;
  logic                   word_done, seq_done, accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Bit-level receiver; byte_valid_q / frame_err_q are registered one cycle after the stop sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_s_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt_q        <= '0;
            state_q      <= IDLE;
            byte_valid_q <= rx_s_q;
            frame_err_q  <= !rx_s_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign word_done = byte_valid_q && (byte_idx_q == BIDX_W'(BYTES_PER_WORD - 1));
  assign seq_done  = word_done && (word_idx_q == WIDX_W'(DEPTH - 1));
  assign accept    = seq_valid_q && seq_ready;

  // The last word is merged combinationally so the finished sequence can load in one step.
  always_comb begin
    word_d = word_q;
    word_d[{byte_idx_q, 3'b000} +: 8] = shift_q;
    asm_d = asm_q;
    asm_d[word_idx_q*WIDTH +: WIDTH] = word_d;
  end

  // NOTE: word/assembly storage has no reset; every lane is rewritten before it is presented.
  always_ff @(posedge clk) begin
    if (byte_valid_q) begin
      word_q <= word_d;
      if (word_done) asm_q <= asm_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx_q  <= '0;
      word_idx_q  <= '0;
      to_cnt_q    <= '0;
      seq_data_q  <= '0;
      seq_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      seq_count_q <= '0;
    end else begin
      overrun_q <= 1'b0;
      if (byte_valid_q) begin
        to_cnt_q <= '0;
        if (word_done) begin
          byte_idx_q <= '0;
          word_idx_q <= word_idx_q + 1'b1;
        end else begin
          byte_idx_q <= byte_idx_q + 1'b1;
        end
      end else if (state_q != IDLE || byte_idx_q == '0) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q == TO_W'(TIMEOUT_CLKS - 1)) begin
        to_cnt_q   <= '0;
        byte_idx_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end

      if (accept) begin
        seq_valid_q <= 1'b0;
        seq_count_q <= seq_count_q + 16'd1;
      end
      if (seq_done) begin
        if (!seq_valid_q || accept) begin
          seq_valid_q <= 1'b1;
          seq_data_q  <= asm_d;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign seq_data  = seq_data_q;
  assign seq_valid = seq_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign seq_count = seq_count_q;
endmodule
